// File: rtl/alu_mcycle_ctrl.sv
// Unsigned 32x32 multiply / 32/32 divide sequencer that borrows the shared execute-stage ALU.
// Latency: Start sampled at edge k -> Busy k+1..k+32, Done pulse k+33 (divide by zero: Done at k+1).
// No backpressure: Start is honoured only in IDLE; hazard logic stalls the pipeline on Busy.
module alu_mcycle_ctrl (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic        MCycleOp,
    input  logic [31:0] Operand1,
    input  logic [31:0] Operand2,
    input  logic [31:0] AluResult,
    input  logic [3:0]  AluFlags,
    output logic        AluSel,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    output logic [1:0]  AluControl,
    output logic        Busy,
    output logic        Done,
    output logic        DivByZero,
    output logic [31:0] Result1,
    output logic [31:0] Result2
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic [31:0] div_q, div_d;
    logic [31:0] h_q, h_d;
    logic [31:0] l_q, l_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] res1_q, res1_d;
    logic [31:0] res2_q, res2_d;
    logic        dbz_q, dbz_d;

    logic [31:0] alu_a, alu_b;
    logic [1:0]  alu_ctrl;
    logic [31:0] shifted;
    logic        alu_c;
    logic        unused_flags;

    assign alu_c        = AluFlags[1];
    assign unused_flags = ^{AluFlags[3:2], AluFlags[0]};
    assign shifted      = {h_q[30:0], l_q[31]};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        div_d    = div_q;
        h_d      = h_q;
        l_d      = l_q;
        cnt_d    = cnt_q;
        res1_d   = res1_q;
        res2_d   = res2_q;
        dbz_d    = dbz_q;
        alu_a    = 32'd0;
        alu_b    = 32'd0;
        alu_ctrl = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d  = MCycleOp;
                    div_d = Operand2;
                    h_d   = 32'd0;
                    l_d   = Operand1;
                    cnt_d = 5'd0;
                    dbz_d = 1'b0;
                    if (MCycleOp && (Operand2 == 32'd0)) begin
                        res1_d  = 32'hFFFF_FFFF;
                        res2_d  = Operand1;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                alu_b = div_q;
                if (!op_q) begin
                    // Shift-add: the ALU carry becomes the new top bit of H.
                    alu_a    = h_q;
                    alu_ctrl = 2'b00;
                    if (l_q[0]) begin
                        h_d = {alu_c, AluResult[31:1]};
                        l_d = {AluResult[0], l_q[31:1]};
                    end else begin
                        h_d = {1'b0, h_q[31:1]};
                        l_d = {h_q[0], l_q[31:1]};
                    end
                end else begin
                    // Restoring step: a set H[31] means the shifted value exceeds 32 bits, so it always fits.
                    alu_a    = shifted;
                    alu_ctrl = 2'b01;
                    if (h_q[31] || alu_c) begin
                        h_d = AluResult;
                        l_d = {l_q[30:0], 1'b1};
                    end else begin
                        h_d = shifted;
                        l_d = {l_q[30:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    res1_d  = l_d;
                    res2_d  = h_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            div_q   <= 32'd0;
            h_q     <= 32'd0;
            l_q     <= 32'd0;
            cnt_q   <= 5'd0;
            res1_q  <= 32'd0;
            res2_q  <= 32'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            div_q   <= div_d;
            h_q     <= h_d;
            l_q     <= l_d;
            cnt_q   <= cnt_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
            dbz_q   <= dbz_d;
        end
    end

    assign AluSel     = (state_q == S_RUN);
    assign Busy       = (state_q == S_RUN);
    assign Done       = (state_q == S_DONE);
    assign AluA       = alu_a;
    assign AluB       = alu_b;
    assign AluControl = alu_ctrl;
    assign DivByZero  = dbz_q;
    assign Result1    = res1_q;
    assign Result2    = res2_q;

endmodule

// File: tb/tb_alu_mcycle_ctrl.sv
// Bench for alu_mcycle_ctrl: behavioural ALU, vector table, corner-case sequences and a random regression
// against a 64-bit reference model, with expected results queued at launch and popped on Done.
module tb_alu_mcycle_ctrl;

    logic        clk;
    logic        Reset;
    logic        Start;
    logic        MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] AluResult;
    logic [3:0]  AluFlags;
    logic        AluSel;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic [1:0]  AluControl;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] Result1;
    logic [31:0] Result2;

    alu_mcycle_ctrl dut (
        .CLK        (clk),
        .Reset      (Reset),
        .Start      (Start),
        .MCycleOp   (MCycleOp),
        .Operand1   (Operand1),
        .Operand2   (Operand2),
        .AluResult  (AluResult),
        .AluFlags   (AluFlags),
        .AluSel     (AluSel),
        .AluA       (AluA),
        .AluB       (AluB),
        .AluControl (AluControl),
        .Busy       (Busy),
        .Done       (Done),
        .DivByZero  (DivByZero),
        .Result1    (Result1),
        .Result2    (Result2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: subtract carry is "no borrow" (A + ~B + 1).
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum = 33'd0;
        case (AluControl)
            2'b00: alu_sum = {1'b0, AluA} + {1'b0, AluB};
            2'b01: alu_sum = {1'b0, AluA} + {1'b0, ~AluB} + 33'd1;
            2'b10: alu_sum = {1'b0, AluA & AluB};
            default: alu_sum = {1'b0, AluA | AluB};
        endcase
        AluResult = alu_sum[31:0];
        AluFlags  = {alu_sum[31], (alu_sum[31:0] == 32'd0), alu_sum[32], 1'b0};
    end

    typedef struct {
        logic        r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic [31:0] r_q1;
        logic [31:0] r_q2;
        logic        r_dbz;
        int          r_lat;
    } vec_t;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        logic        edbz;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {58'd0, AluSel, Busy, Done, DivByZero, AluControl}, 64'd0);
        check({tag, "_res"}, {Result2, Result1}, 64'd0);
        check({tag, "_alu"}, {AluA, AluB}, 64'd0);
    endtask

    task automatic ref_model(input logic op, input logic [31:0] a, input logic [31:0] b,
                             output exp_t e);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        if (!op) begin
            e.e1 = p[31:0]; e.e2 = p[63:32]; e.edbz = 1'b0;
        end else if (b == 32'd0) begin
            e.e1 = 32'hFFFF_FFFF; e.e2 = a; e.edbz = 1'b1;
        end else begin
            e.e1 = a / b; e.e2 = a % b; e.edbz = 1'b0;
        end
    endtask

    // Called at a sample point in IDLE; returns at the IDLE sample point after the Done cycle.
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input int lat);
        int   cyc;
        exp_t got;
        sb.push_back(e);
        MCycleOp = op; Operand1 = a; Operand2 = b; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        MCycleOp = ~op; Operand1 = $urandom; Operand2 = $urandom;
        cyc = 1;
        if (lat != 1) check("dbz_cleared_at_start", {63'd0, DivByZero}, 64'd0);
        while (Done !== 1'b1 && cyc < 40) begin
            check("run_ctl", {29'd0, Busy, AluSel, AluControl, AluB}, {29'd0, 1'b1, 1'b1, 1'b0, op, b});
            @(posedge clk); #1;
            cyc++;
        end
        check("done_latency", cyc, lat);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            if (Done === 1'b1) begin
                check("result", {Result2, Result1}, {got.e2, got.e1});
                check("div_by_zero", {63'd0, DivByZero}, {63'd0, got.edbz});
                check("done_idle_alu", {27'd0, Busy, AluSel, AluControl, AluA}, 64'd0);
                check("done_alub", {32'd0, AluB}, 64'd0);
            end
        end
        @(posedge clk); #1;
        check("done_pulse_ends", {62'd0, Done, Busy}, 64'd0);
        check("result_held", {31'd0, DivByZero, Result2, Result1}, {31'd0, e.edbz, e.e2, e.e1});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   ndone;
        logic seen_done;
        logic op;
        logic [31:0] a, b;

        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33};
        vecs[1] = '{1'b1, 32'd100,       32'd7,         32'd14,        32'd2,        1'b0, 33};
        vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,        1'b0, 33};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33};
        vecs[4] = '{1'b1, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1};
        vecs[5] = '{1'b0, 32'd0,         32'h1234_5678, 32'd0,         32'd0,        1'b0, 33};
        vecs[6] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0,         32'd1,        1'b0, 33};
        vecs[7] = '{1'b1, 32'd5,         32'd10,        32'd0,         32'd5,        1'b0, 33};

        Reset = 1'b1; Start = 1'b0; MCycleOp = 1'b0; Operand1 = 32'd0; Operand2 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        Reset = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero("idle_after_reset");

        for (int i = 0; i < 8; i++) begin
            e.e1 = vecs[i].r_q1; e.e2 = vecs[i].r_q2; e.edbz = vecs[i].r_dbz;
            run_op(vecs[i].r_op, vecs[i].r_a, vecs[i].r_b, e, vecs[i].r_lat);
        end

        // Start held high: second launch only once IDLE is reached, mid-run operand changes ignored.
        MCycleOp = 1'b0; Operand1 = 32'd3; Operand2 = 32'd5; Start = 1'b1;
        e.e1 = 32'd15; e.e2 = 32'd0; e.edbz = 1'b0;
        sb.push_back(e);
        sb.push_back(e);
        ndone = 0;
        @(posedge clk); #1;
        for (int c = 1; c <= 68; c++) begin
            if (c == 5) begin
                MCycleOp = 1'b1; Operand1 = 32'd9; Operand2 = 32'd9;
            end
            if (c == 20) begin
                MCycleOp = 1'b0; Operand1 = 32'd3; Operand2 = 32'd5;
            end
            if (c == 68) Start = 1'b0;
            if (Done === 1'b1) begin
                ndone++;
                check("cont_done_cycle", c, (ndone == 1) ? 33 : 67);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("cont_result", {Result2, Result1}, {e.e2, e.e1});
                end
            end
            if (c < 68) begin
                @(posedge clk); #1;
            end
        end
        check("cont_done_count", ndone, 2);
        @(posedge clk); #1;
        check("cont_no_third_launch", {63'd0, Busy}, 64'd0);
        sb.delete();

        // Reset in the middle of RUN aborts without a Done.
        MCycleOp = 1'b0; Operand1 = 32'h1234; Operand2 = 32'h5678; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("busy_before_abort", {63'd0, Busy}, 64'd1);
        Reset = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("mid_run_reset");
        Reset = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (Done === 1'b1) seen_done = 1'b1;
        end
        check("no_done_after_abort", {63'd0, seen_done}, 64'd0);
        e.e1 = 32'd42; e.e2 = 32'd0; e.edbz = 1'b0;
        run_op(1'b0, 32'd6, 32'd7, e, 33);

        for (int n = 0; n < 1000; n++) begin
            op = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 255);
                2: b = $urandom_range(0, 15);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            ref_model(op, a, b, e);
            run_op(op, a, b, e, (op && b == 32'd0) ? 1 : 33);
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
